// File: rtl/gray_updown_nbits_if.sv
// Control and count signals of the Gray up/down counter.
// The master side drives the controls, the slave side is the counter itself.
interface gray_updown_nbits_if #(
    parameter int N = 4
);
    logic         en;
    logic         step_btn;
    logic         dir;
    logic         load;
    logic [N-1:0] load_val;
    logic [N-1:0] gray_out;
    logic [N-1:0] bin_out;
    logic         tc;
    logic         step_ack;

    modport master (
        output en, step_btn, dir, load, load_val,
        input  gray_out, bin_out, tc, step_ack
    );

    modport slave (
        input  en, step_btn, dir, load, load_val,
        output gray_out, bin_out, tc, step_ack
    );
endinterface

// File: rtl/gray_updown_nbits.sv
// N-bit reflected Gray up/down counter stepped by a debounced push-button,
// with synchronous load, optional saturation and a terminal-count pulse.
module gray_updown_nbits #(
    parameter int N         = 4,
    parameter int DB_CYCLES = 16,
    parameter int SATURATE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    gray_updown_nbits_if.slave    bus
);
    localparam int            CW        = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(DB_CYCLES - 1);
    localparam logic [N-1:0]  ALL_ONES  = '1;

    logic          sync_q1, sync_q2;
    logic          db_lvl, db_lvl_q;
    logic [CW-1:0] hold_cnt;
    logic          step_pulse, accept, at_term;
    logic [N-1:0]  gray_q, bin_q;
    logic          tc_q, ack_q;
    logic [N-1:0]  step_bin, next_gray, next_bin;

    function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= bus.step_btn;
            sync_q2 <= sync_q1;
        end
    end

    // The level only flips after DB_CYCLES consecutive disagreeing samples;
    // any agreeing sample restarts the hold count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_lvl   <= 1'b0;
            db_lvl_q <= 1'b0;
            hold_cnt <= '0;
        end else begin
            db_lvl_q <= db_lvl;
            if (sync_q2 == db_lvl) begin
                hold_cnt <= '0;
            end else if (hold_cnt == HOLD_LAST) begin
                db_lvl   <= sync_q2;
                hold_cnt <= '0;
            end else begin
                hold_cnt <= hold_cnt + CW'(1);
            end
        end
    end

    assign step_pulse = db_lvl & ~db_lvl_q;
    assign accept     = step_pulse & bus.en;
    assign at_term    = bus.dir ? (bin_q == ALL_ONES) : (bin_q == '0);

    // Stepping is done in binary and re-encoded, so the Gray output moves by one code.
    always_comb begin
        step_bin  = bus.dir ? (bin_q + N'(1)) : (bin_q - N'(1));
        next_gray = gray_q;
        next_bin  = bin_q;
        if (bus.load) begin
            next_gray = bus.load_val;
            next_bin  = gray2bin(bus.load_val);
        end else if (accept && !(at_term && (SATURATE != 0))) begin
            next_bin  = step_bin;
            next_gray = step_bin ^ (step_bin >> 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_q <= '0;
            bin_q  <= '0;
            tc_q   <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            gray_q <= next_gray;
            bin_q  <= next_bin;
            tc_q   <= accept & ~bus.load & at_term;
            ack_q  <= accept & ~bus.load;
        end
    end

    assign bus.gray_out = gray_q;
    assign bus.bin_out  = bin_q;
    assign bus.tc       = tc_q;
    assign bus.step_ack = ack_q;
endmodule

// File: tb/tb_gray_updown_nbits.sv
// Drives a wrapping and a saturating counter with identical stimulus and
// scores every step against a table-driven Gray sequence model.
module tb_gray_updown_nbits;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1, btn = 1'b0, dir = 1'b1, load = 1'b0;
    logic [3:0] load_val = 4'h0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         acks = 0;

    typedef struct {
        int         exp_cyc;
        logic [3:0] gw;
        logic       tw;
        logic [3:0] gs;
        logic       ts;
    } step_exp_t;

    step_exp_t  sb[$];
    step_exp_t  mon_e;
    logic [3:0] mw = 4'h0, ms = 4'h0;
    logic [3:0] seq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                             4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    gray_updown_nbits_if #(.N(4)) ifw ();
    gray_updown_nbits_if #(.N(4)) ifs ();

    assign ifw.en = en;   assign ifw.step_btn = btn; assign ifw.dir = dir;
    assign ifw.load = load; assign ifw.load_val = load_val;
    assign ifs.en = en;   assign ifs.step_btn = btn; assign ifs.dir = dir;
    assign ifs.load = load; assign ifs.load_val = load_val;

    gray_updown_nbits #(.N(4), .DB_CYCLES(DB), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .bus(ifw.slave)
    );
    gray_updown_nbits #(.N(4), .DB_CYCLES(DB), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .bus(ifs.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int binOf(input logic [3:0] g);
        for (int k = 0; k < 16; k++) begin
            if (seq[k] == g) return k;
        end
        return -1;
    endfunction

    function automatic void nextCode(input logic [3:0] g, input logic d, input bit sat,
                                     output logic [3:0] ng, output logic t);
        int i;
        i = binOf(g);
        t = d ? (i == 15) : (i == 0);
        if (t && sat) ng = g;
        else          ng = seq[d ? (i + 1) % 16 : (i + 15) % 16];
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // base is the cycle count when the clean button rise was presented
    task automatic pushStep(input int base, input logic d);
        step_exp_t e;
        e.exp_cyc = base + DB + 3;
        nextCode(mw, d, 1'b0, e.gw, e.tw);
        nextCode(ms, d, 1'b1, e.gs, e.ts);
        mw = e.gw;
        ms = e.gs;
        sb.push_back(e);
    endtask

    task automatic checkDrained(input string tag);
        checkOutput(tag, sb.size(), 0);
        sb.delete();
    endtask

    task automatic applyStimulus(input logic d);
        @(negedge clk);
        dir = d;
        btn = 1'b1;
        pushStep(cyc, d);
        waitCycles(DB + 6);
        btn = 1'b0;
        waitCycles(DB + 5);
        checkDrained("drain");
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, "_gw"}, int'(ifw.gray_out), 0);
        checkOutput({tag, "_bw"}, int'(ifw.bin_out), 0);
        checkOutput({tag, "_tw"}, int'(ifw.tc), 0);
        checkOutput({tag, "_aw"}, int'(ifw.step_ack), 0);
        checkOutput({tag, "_gs"}, int'(ifs.gray_out), 0);
        checkOutput({tag, "_bs"}, int'(ifs.bin_out), 0);
        checkOutput({tag, "_ts"}, int'(ifs.tc), 0);
        checkOutput({tag, "_as"}, int'(ifs.step_ack), 0);
    endtask

    // Every acknowledged step is matched to the oldest expected step.
    always @(negedge clk) begin
        if (!rst) begin
            if (ifw.step_ack) begin
                acks++;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_ack", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("latency", cyc, mon_e.exp_cyc);
                    checkOutput("gray_w", int'(ifw.gray_out), int'(mon_e.gw));
                    checkOutput("bin_w", int'(ifw.bin_out), binOf(mon_e.gw));
                    checkOutput("tc_w", int'(ifw.tc), int'(mon_e.tw));
                    checkOutput("ack_s", int'(ifs.step_ack), 1);
                    checkOutput("gray_s", int'(ifs.gray_out), int'(mon_e.gs));
                    checkOutput("bin_s", int'(ifs.bin_out), binOf(mon_e.gs));
                    checkOutput("tc_s", int'(ifs.tc), int'(mon_e.ts));
                end
            end else if (ifs.step_ack) begin
                checkOutput("ack_s_only", 1, 0);
            end
            if ((ifw.tc && !ifw.step_ack) || (ifs.tc && !ifs.step_ack))
                checkOutput("tc_without_ack", 1, 0);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int a0;

        waitCycles(3);
        checkZero("reset");
        rst = 1'b0;

        $display("[TB] full walk of 16 steps upward");
        for (int k = 0; k < 16; k++) applyStimulus(1'b1);

        $display("[TB] bouncing button");
        a0 = acks;
        @(negedge clk);
        dir = 1'b1;
        for (int k = 0; k < 5; k++) begin
            btn = 1'b1; waitCycles(2);
            btn = 1'b0; waitCycles(2);
        end
        btn = 1'b1;
        pushStep(cyc, 1'b1);
        waitCycles(10);
        btn = 1'b0;
        waitCycles(DB + 5);
        checkDrained("bounce_drain");
        checkOutput("bounce_acks", acks - a0, 1);

        $display("[TB] load terminal value then step both ways");
        @(negedge clk);
        load = 1'b1; load_val = 4'b1000;
        @(negedge clk);
        load = 1'b0;
        mw = 4'b1000; ms = 4'b1000;
        checkOutput("load_gw", int'(ifw.gray_out), 8);
        checkOutput("load_bw", int'(ifw.bin_out), 15);
        checkOutput("load_gs", int'(ifs.gray_out), 8);
        applyStimulus(1'b1);
        applyStimulus(1'b0);

        $display("[TB] load coincident with accepted step");
        @(negedge clk);
        dir = 1'b1; btn = 1'b1;
        base = cyc;
        while (cyc < base + DB + 2) @(negedge clk);
        load = 1'b1; load_val = 4'b0110;
        @(negedge clk);
        load = 1'b0;
        mw = 4'b0110; ms = 4'b0110;
        checkOutput("ldwin_gw", int'(ifw.gray_out), 6);
        checkOutput("ldwin_bw", int'(ifw.bin_out), 4);
        checkOutput("ldwin_aw", int'(ifw.step_ack), 0);
        checkOutput("ldwin_tw", int'(ifw.tc), 0);
        checkOutput("ldwin_gs", int'(ifs.gray_out), 6);
        checkOutput("ldwin_as", int'(ifs.step_ack), 0);
        waitCycles(DB + 4);
        btn = 1'b0;
        waitCycles(DB + 5);
        checkOutput("ldwin_hold", int'(ifw.gray_out), 6);

        $display("[TB] press while disabled");
        a0 = acks;
        @(negedge clk);
        en = 1'b0; btn = 1'b1;
        waitCycles(DB + 6);
        en = 1'b1;
        waitCycles(DB + 4);
        checkOutput("en0_gw", int'(ifw.gray_out), int'(mw));
        checkOutput("en0_gs", int'(ifs.gray_out), int'(ms));
        checkOutput("en0_acks", acks - a0, 0);
        btn = 1'b0;
        waitCycles(DB + 5);
        applyStimulus(1'b1);

        $display("[TB] reset in the middle of debounce");
        @(negedge clk);
        dir = 1'b1; btn = 1'b1;
        base = cyc;
        while (cyc < base + 4) @(negedge clk);
        rst = 1'b1;
        #1;
        checkZero("midrst");
        waitCycles(2);
        rst = 1'b0;
        mw = 4'h0; ms = 4'h0;
        pushStep(cyc, 1'b1);
        waitCycles(DB + 6);
        btn = 1'b0;
        waitCycles(DB + 5);
        checkDrained("midrst_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
